// File: rtl/line_engine_q.sv
// Queued Bresenham line engine writing single pixels into a DDR framebuffer over the af/wdf FIFOs.
// Optional clipping to FB_WIDTH x FB_HEIGHT when LINE_ENGINE_Q_CLIP_EN is defined.
module line_engine_q #(
  parameter int          COORD_W   = 10,
  parameter int          ROW_SHIFT = 10,
  parameter logic [30:0] FB_BASE   = 31'h0100_0000,
  parameter int          CMD_DEPTH = 4,
  parameter int          FB_WIDTH  = 800,
  parameter int          FB_HEIGHT = 600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [31:0]        cmd_color,
  output logic               busy,
  output logic [15:0]        lines_done,
  input  logic               af_full,
  input  logic               wdf_full,
  output logic [30:0]        af_addr_din,
  output logic               af_wr_en,
  output logic [127:0]       wdf_din,
  output logic [15:0]        wdf_mask_din,
  output logic               wdf_wr_en
);
  localparam int SW = COORD_W + 2;
  localparam int AW = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic [31:0]        color;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ISSUE0, ISSUE1} state_t;

  cmd_t          q [CMD_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push;
  state_t        state;
  cmd_t          cur;

  logic                 steep, yneg;
  logic signed [SW-1:0] x, y, xe, dxr, dyr, err;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign busy      = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr[AW-1:0]] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
  end

  // Setup: normalise the popped command into an x-major, left-to-right line.
  logic signed [SW-1:0] ux0, uy0, ux1, uy1, adx, ady;
  logic signed [SW-1:0] sx0, sy0, sx1, sy1, bx0, by0, bx1, by1, dx_c;
  logic                 steep_c;

  always_comb begin
    ux0 = SW'(cur.x0);
    uy0 = SW'(cur.y0);
    ux1 = SW'(cur.x1);
    uy1 = SW'(cur.y1);
    adx = (ux1 >= ux0) ? ux1 - ux0 : ux0 - ux1;
    ady = (uy1 >= uy0) ? uy1 - uy0 : uy0 - uy1;
    steep_c = ady > adx;
    sx0 = steep_c ? uy0 : ux0;
    sy0 = steep_c ? ux0 : uy0;
    sx1 = steep_c ? uy1 : ux1;
    sy1 = steep_c ? ux1 : uy1;
    bx0 = sx0; by0 = sy0; bx1 = sx1; by1 = sy1;
    if (sx0 > sx1) begin
      bx0 = sx1; by0 = sy1; bx1 = sx0; by1 = sy0;
    end
    dx_c = bx1 - bx0;
  end

  // Pixel address and lane selection for the current point.
  logic signed [SW-1:0] px, py, err_n;
  logic [30:0]          pa;
  logic [2:0]           w;
  logic [15:0]          lane_m;
  logic                 clip, adv0, adv1, issuing;

  always_comb begin
    px     = steep ? y : x;
    py     = steep ? x : y;
    pa     = FB_BASE + (31'($unsigned(py)) << ROW_SHIFT) + 31'($unsigned(px));
    w      = pa[2:0];
    lane_m = ~(16'hF << {w[1:0], 2'b00});
    err_n  = err - dyr;
`ifdef LINE_ENGINE_Q_CLIP_EN
    clip = (int'($unsigned(px)) >= FB_WIDTH) || (int'($unsigned(py)) >= FB_HEIGHT);
`else
    clip = 1'b0;
`endif
  end

  // Clipped pixels step through both issue states in one cycle each, ignoring FIFO status.
  assign adv0    = (state == ISSUE0) && (clip || (!af_full && !wdf_full));
  assign adv1    = (state == ISSUE1) && (clip || !wdf_full);
  assign issuing = (state == ISSUE0) || (state == ISSUE1);

  assign af_wr_en     = adv0 && !clip;
  assign wdf_wr_en    = (adv0 || adv1) && !clip;
  assign af_addr_din  = issuing ? {pa[30:3], 3'b000} : '0;
  assign wdf_din      = issuing ? {4{cur.color}} : '0;
  assign wdf_mask_din = (state == ISSUE0) ? (w[2] ? 16'hFFFF : lane_m) :
                        (state == ISSUE1) ? (w[2] ? lane_m : 16'hFFFF) : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      cur        <= '0;
      steep      <= 1'b0;
      yneg       <= 1'b0;
      x          <= '0;
      y          <= '0;
      xe         <= '0;
      dxr        <= '0;
      dyr        <= '0;
      err        <= '0;
      lines_done <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          cur    <= q[rd_ptr[AW-1:0]];
          rd_ptr <= rd_ptr + (AW+1)'(1);
          state  <= SETUP;
        end
        SETUP: begin
          steep <= steep_c;
          x     <= bx0;
          y     <= by0;
          xe    <= bx1;
          dxr   <= dx_c;
          dyr   <= (by1 >= by0) ? by1 - by0 : by0 - by1;
          yneg  <= !(by1 > by0);
          err   <= dx_c >>> 1;
          state <= ISSUE0;
        end
        ISSUE0: if (adv0) state <= ISSUE1;
        ISSUE1: if (adv1) begin
          if (x == xe) begin
            lines_done <= lines_done + 16'd1;
            state      <= IDLE;
          end else begin
            x <= x + SW'(1);
            if (err_n < 0) begin
              y   <= yneg ? y - SW'(1) : y + SW'(1);
              err <= err_n + dxr;
            end else begin
              err <= err_n;
            end
            state <= ISSUE0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_engine_q.sv
// Scoreboard bench for line_engine_q: a textbook Bresenham model queues expected pixel writes,
// a monitor pops them on every FIFO push.
module tb_line_engine_q;
  localparam int          CW   = 10;
  localparam int          ROW  = 1024;
  localparam logic [30:0] BASE = 31'h0100_0000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [31:0]   cmd_color = '0;
  logic          busy;
  logic [15:0]   lines_done;
  logic          af_full, wdf_full;
  logic [30:0]   af_addr_din;
  logic          af_wr_en, wdf_wr_en;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;

  logic rand_full = 1'b0, af_dir = 1'b0, wdf_dir = 1'b0, af_rnd = 1'b0, wdf_rnd = 1'b0;
  assign af_full  = rand_full ? af_rnd  : af_dir;
  assign wdf_full = rand_full ? wdf_rnd : wdf_dir;

  always #5 clk = ~clk;

  line_engine_q dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .busy(busy), .lines_done(lines_done), .af_full(af_full), .wdf_full(wdf_full),
    .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
  );

  typedef struct { logic [30:0] pa; logic [31:0] color; } px_t;
  px_t exp_q[$];
  px_t pend;
  bit  have_b1 = 0;
  int  checks = 0, failures = 0, accepted = 0, n_af = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [15:0] exp_mask(logic [30:0] pa, bit beat1);
    logic [15:0] m = 16'hFFFF;
    int wi = int'(pa[2:0]);
    if ((wi >= 4) == beat1) m[4*(wi%4) +: 4] = 4'h0;
    return m;
  endfunction

  // Reference: classic Bresenham, plotting every x from left to right on the major axis.
  function automatic void plot_line(int x0, int y0, int x1, int y1, logic [31:0] c);
    int t, dx, dy, err, yy, ys, px, py;
    bit steep;
    px_t e;
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx = x1 - x0; dy = iabs(y1 - y0); err = dx / 2; yy = y0;
    ys = (y1 > y0) ? 1 : -1;
    for (int xx = x0; xx <= x1; xx++) begin
      px = steep ? yy : xx;
      py = steep ? xx : yy;
      e.pa = BASE + 31'(py * ROW + px);
      e.color = c;
      exp_q.push_back(e);
      err -= dy;
      if (err < 0) begin yy += ys; err += dx; end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    af_rnd  = ($urandom % 3) == 0;
    wdf_rnd = ($urandom % 4) == 0;
  end

  // Monitor: every FIFO push is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (af_wr_en) begin
        check("af_not_full", af_full, 1'b0);
        check("beat0_pair", wdf_wr_en, 1'b1);
        if (exp_q.size() == 0) begin
          check("unexpected_af_write", af_wr_en, 1'b0);
        end else begin
          pend = exp_q.pop_front();
          n_af++;
          check("af_addr", af_addr_din, {pend.pa[30:3], 3'b000});
          check("beat0_data", wdf_din, {4{pend.color}});
          check("beat0_mask", wdf_mask_din, exp_mask(pend.pa, 1'b0));
          have_b1 = 1;
        end
      end else if (wdf_wr_en) begin
        check("wdf_not_full", wdf_full, 1'b0);
        check("beat1_expected", have_b1, 1'b1);
        check("beat1_data", wdf_din, {4{pend.color}});
        check("beat1_mask", wdf_mask_din, exp_mask(pend.pa, 1'b1));
        have_b1 = 0;
      end
    end
  end

  task automatic send(int x0, int y0, int x1, int y1, logic [31:0] c, int max_wait);
    bit got = 0, ok = 0;
    cmd_x0 = x0[CW-1:0]; cmd_y0 = y0[CW-1:0]; cmd_x1 = x1[CW-1:0]; cmd_y1 = y1[CW-1:0];
    cmd_color = c; cmd_valid = 1'b1;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk); got = cmd_ready;
      @(posedge clk); #1;
      if (got) begin ok = 1; plot_line(x0, y0, x1, y1, c); accepted++; end
    end
    cmd_valid = 1'b0;
    check("cmd_accept", ok, 1'b1);
  endtask

  task automatic wait_beat(bit first, string name);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = first ? af_wr_en : (wdf_wr_en && !af_wr_en);
    end
    check(name, seen, 1'b1);
  endtask

  task automatic drain(string name);
    int i = 0;
    while ((busy || exp_q.size() != 0 || have_b1) && i < 20000) begin
      @(negedge clk); i++;
    end
    check(name, (i < 20000), 1'b1);
    check({name, "_lines_done"}, lines_done, 16'(accepted));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0]  a0;
    logic [127:0] d0;
    logic [15:0]  m0;
    int nacc, n_before;
    bit got;

    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_lines_done", lines_done, 16'h0);
    check("rst_enables", {af_wr_en, wdf_wr_en}, 2'b00);
    check("rst_addr", af_addr_din, 31'h0);
    check("rst_data", {wdf_din, wdf_mask_din}, 144'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Horizontal line, then busy must fall two cycles after the last address push.
    send(0, 0, 3, 0, 32'h00FF_0000, 10);
    repeat (4) wait_beat(1'b1, "t1_beat0");
    @(negedge clk); #1 check("t1_busy_during_beat1", busy, 1'b1);
    @(negedge clk); #1 check("t1_busy_fall", busy, 1'b0);
    drain("t1");

    send(2, 1, 3, 5, 32'h0000_FF00, 10);
    drain("t2_steep");
    send(5, 5, 0, 0, 32'h0000_00FF, 10);
    drain("t3_reversed");

    // Stall the address FIFO in ISSUE0, then the data FIFO in ISSUE1.
    send(0, 10, 60, 13, 32'h0012_3456, 10);
    wait_beat(1'b0, "t4_first_beat1");
    @(posedge clk); #1 af_dir = 1'b1;
    @(negedge clk); #1;
    a0 = af_addr_din; d0 = wdf_din; m0 = wdf_mask_din;
    check("t4_af_stall_enables", {af_wr_en, wdf_wr_en}, 2'b00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      check("t4_af_stall_enables", {af_wr_en, wdf_wr_en}, 2'b00);
      check("t4_af_stall_stable", {af_addr_din, wdf_din, wdf_mask_din}, {a0, d0, m0});
    end
    @(posedge clk); #1 af_dir = 1'b0;
    wait_beat(1'b1, "t4_beat0_after_stall");
    @(posedge clk); #1 wdf_dir = 1'b1;
    @(negedge clk); #1;
    a0 = af_addr_din; m0 = wdf_mask_din;
    for (int i = 0; i < 3; i++) begin
      check("t4_wdf_stall_enables", {af_wr_en, wdf_wr_en}, 2'b00);
      check("t4_wdf_stall_stable", {af_addr_din, wdf_mask_din}, {a0, m0});
      @(negedge clk); #1;
    end
    @(posedge clk); #1 wdf_dir = 1'b0;
    drain("t4");

    // Queue overflow: a long line keeps the engine busy while five commands are offered.
    send(0, 20, 200, 20, 32'h00AA_BBCC, 10);
    repeat (4) @(posedge clk);
    #1 nacc = 0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cmd_x0 = CW'(k); cmd_y0 = CW'(40 + k); cmd_x1 = CW'(k + 6); cmd_y1 = CW'(42 + k);
      cmd_color = 32'h0010_0000 + 32'(k);
      @(negedge clk); got = cmd_ready;
      @(posedge clk); #1;
      if (got) begin plot_line(k, 40 + k, k + 6, 42 + k, 32'h0010_0000 + 32'(k)); accepted++; nacc++; end
    end
    cmd_valid = 1'b0;
    check("t5_accepted", nacc, 4);
    check("t5_cmd_ready_full", cmd_ready, 1'b0);
    drain("t5");

    // Randomised lines with random FIFO back-pressure, plus edge cases.
    rand_full = 1'b1;
    send(7, 3, 7, 3, 32'h0055_5555, 200);
    send(1023, 1023, 1019, 1021, 32'h0001_0203, 200);
    send(5, 0, 5, 12, 32'h0077_0000, 200);
    send(10, 20, 8, 2, 32'h0000_7700, 200);
    for (int k = 0; k < 20; k++)
      send($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
           $urandom_range(0, 40), $urandom & 32'h00FF_FFFF, 200);
    drain("t_random");
    rand_full = 1'b0;

    // Reset during the third pixel of a ten-pixel line.
    send(0, 30, 9, 30, 32'h0033_3333, 10);
    repeat (3) wait_beat(1'b1, "t6_beat0");
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete(); have_b1 = 0; accepted = 0;
    check("t6_enables", {af_wr_en, wdf_wr_en}, 2'b00);
    check("t6_cmd_ready", cmd_ready, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_lines_done", lines_done, 16'h0);
    n_before = n_af;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("t6_no_writes", n_af, n_before);
    check("t6_busy_after", busy, 1'b0);
    send(3, 3, 6, 4, 32'h0044_4444, 10);
    drain("t6_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
